address_generator: RTL and testbench

Parametrised successor to the PMBIST address counter. Produces the test address sequence for the march engine in three modes: linear up/down, LFSR pseudo-random up/down and row-fast (field-swapped) linear. It adds programmable address bounds, a configurable polynomial and seed, and a registered terminal-count (`done_out`) pulse that tells the controller a march element has completed.

---
 rtl/address_generator_pkg.sv | 17 +
 rtl/address_generator_if.sv | 27 ++
 rtl/address_generator_lfsr_step.sv | 16 +
 rtl/address_generator.sv | 81 ++++++++
 tb/tb_address_generator.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/address_generator_pkg.sv
// Shared address-mode encodings, direction constants and default width
// for the march-engine address generator.
package address_generator_pkg;

  typedef enum logic [1:0] {
    ADMD_LIUD = 2'b00,
    ADMD_PRUD = 2'b01,
    ADMD_ROWF = 2'b10,
    ADMD_RSVD = 2'b11
  } admd_t;

  localparam logic ADDR_UP   = 1'b1;
  localparam logic ADDR_DOWN = 1'b0;

  localparam int unsigned ADDR_WIDTH_DEF = 8;

endpackage

// File: rtl/address_generator_if.sv
// Control/address bundle between the march controller (master) and the
// address generator (slave).
interface address_generator_if #(
  parameter int unsigned W = 8
) ();

  logic [1:0]   admd_in;
  logic         hold_in;
  logic         updwn_in;
  logic         s_in;
  logic         r_in;
  logic [W-1:0] lo_in;
  logic [W-1:0] hi_in;
  logic [W-1:0] tas_out;
  logic         done_out;

  modport master (
    output admd_in, hold_in, updwn_in, s_in, r_in, lo_in, hi_in,
    input  tas_out, done_out
  );

  modport slave (
    input  admd_in, hold_in, updwn_in, s_in, r_in, lo_in, hi_in,
    output tas_out, done_out
  );

endinterface

// File: rtl/address_generator_lfsr_step.sv
// Combinational Fibonacci LFSR step in both directions; next_dn is the
// exact inverse of next_up, given that TAPS[W-1] is set.
module addr_lfsr_step #(
  parameter int unsigned   W    = 8,
  parameter logic [W-1:0]  TAPS = 'hB8
) (
  input  logic [W-1:0] cur,
  output logic [W-1:0] next_up,
  output logic [W-1:0] next_dn
);

  assign next_up = {cur[W-2:0], ^(cur & TAPS)};
  // The bit shifted out on the forward step is recovered from the feedback bit
  assign next_dn = {cur[0] ^ (^(cur[W-1:1] & TAPS[W-2:0])), cur[W-1:1]};

endmodule

// File: rtl/address_generator.sv
// Address generator: linear up/down, LFSR up/down and row-fast linear
// sequences with programmable bounds and a registered wrap pulse.
module address_generator
  import address_generator_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned            COL_BITS   = 4,
  parameter logic [ADDR_WIDTH-1:0]  LFSR_TAPS  = 'hB8,
  parameter logic [ADDR_WIDTH-1:0]  LFSR_SEED  = 'h01
) (
  input  logic                clk,
  input  logic                rst,
  address_generator_if.slave  bus
);

  localparam int unsigned W = ADDR_WIDTH;

  admd_t        mode;
  logic [W-1:0] idx, idx_nxt;
  logic [W-1:0] tas_q, tas_nxt;
  logic         done_q, done_nxt;
  logic [W-1:0] lfsr_up, lfsr_dn;
  logic         up;

  assign mode = admd_t'(bus.admd_in);
  assign up   = (bus.updwn_in == ADDR_UP);

  addr_lfsr_step #(
    .W    (W),
    .TAPS (LFSR_TAPS)
  ) u_lfsr_step (
    .cur     (idx),
    .next_up (lfsr_up),
    .next_dn (lfsr_dn)
  );

  always_comb begin
    idx_nxt  = idx;
    done_nxt = 1'b0;
    if (mode != ADMD_RSVD) begin
      if (bus.s_in) begin
        idx_nxt = (mode == ADMD_PRUD) ? LFSR_SEED : bus.lo_in;
      end else if (bus.r_in) begin
        idx_nxt = (mode == ADMD_PRUD) ? LFSR_SEED : bus.hi_in;
      end else if (!bus.hold_in) begin
        if (mode == ADMD_PRUD) begin
          // All-zero is the LFSR lockup state: escape to the seed silently
          if (idx == '0) begin
            idx_nxt = LFSR_SEED;
          end else begin
            idx_nxt  = up ? lfsr_up : lfsr_dn;
            done_nxt = (idx_nxt == LFSR_SEED);
          end
        end else if (idx == (up ? bus.hi_in : bus.lo_in)) begin
          idx_nxt  = up ? bus.lo_in : bus.hi_in;
          done_nxt = 1'b1;
        end else begin
          idx_nxt = up ? idx + 1'b1 : idx - 1'b1;
        end
      end
    end
    tas_nxt = (mode == ADMD_ROWF) ?
              {idx_nxt[W-COL_BITS-1:0], idx_nxt[W-1:W-COL_BITS]} : idx_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx    <= '0;
      tas_q  <= '0;
      done_q <= 1'b0;
    end else begin
      idx    <= idx_nxt;
      tas_q  <= tas_nxt;
      done_q <= done_nxt;
    end
  end

  assign bus.tas_out  = tas_q;
  assign bus.done_out = done_q;

endmodule

// File: tb/tb_address_generator.sv
// Self-checking bench for address_generator: directed test-plan steps plus
// randomized traffic, checked against a sequence-level reference model.
module tb_address_generator;

  localparam int SEED = 8'h01;
  localparam int TAPS = 8'hB8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  int   m_idx = 0, m_tas = 0, m_done = 0;
  int   seq [255];
  int   pos [256];

  address_generator_if #(.W(8)) bus ();

  address_generator #(
    .ADDR_WIDTH (8),
    .COL_BITS   (4),
    .LFSR_TAPS  (8'hB8),
    .LFSR_SEED  (8'h01)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: linear modes by bound arithmetic, PRUD by position in the
  // precomputed maximal-length sequence.
  task automatic model_edge();
    int mode, lo, hi, p;
    bit up;
    mode   = int'(bus.admd_in);
    lo     = int'(bus.lo_in);
    hi     = int'(bus.hi_in);
    up     = bus.updwn_in;
    m_done = 0;
    if (mode != 3) begin
      if (bus.s_in)       m_idx = (mode == 1) ? SEED : lo;
      else if (bus.r_in)  m_idx = (mode == 1) ? SEED : hi;
      else if (!bus.hold_in) begin
        if (mode == 1) begin
          if (m_idx == 0) m_idx = SEED;
          else begin
            p      = pos[m_idx];
            m_idx  = up ? seq[(p + 1) % 255] : seq[(p + 254) % 255];
            m_done = (m_idx == SEED) ? 1 : 0;
          end
        end else if (m_idx == (up ? hi : lo)) begin
          m_idx  = up ? lo : hi;
          m_done = 1;
        end else begin
          m_idx = (m_idx + (up ? 1 : 255)) % 256;
        end
      end
    end
    m_tas = (mode == 2) ? (((m_idx << 4) | (m_idx >> 4)) & 255) : m_idx;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".tas"}, int'(bus.tas_out), m_tas);
    check({tag, ".done"}, int'(bus.done_out), m_done);
  endtask

  task automatic drive(input int mode, input bit up, input bit s, input bit r,
                       input bit hold);
    bus.admd_in  = 2'(mode);
    bus.updwn_in = up;
    bus.s_in     = s;
    bus.r_in     = r;
    bus.hold_in  = hold;
  endtask

  initial begin
    int v, distinct, dones;
    bit seen [256];

    v = SEED;
    for (int i = 0; i < 255; i++) begin
      seq[i] = v;
      pos[v] = i;
      v = ((v << 1) & 255) | ($countones(v & TAPS) & 1);
    end
    pos[0] = 0;

    drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.lo_in = 8'h10;
    bus.hi_in = 8'h13;
    #12;
    check("reset.tas", int'(bus.tas_out), 0);
    check("reset.done", int'(bus.done_out), 0);
    @(negedge clk);
    rst = 1'b1;

    // PRUD step straight out of reset escapes the zero state
    drive(1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("prud_zero");
    check("prud_zero.const", int'(bus.tas_out), 8'h01);

    // LIUD up 10..13 and wrap
    drive(0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick("liud_up_load");
    bus.s_in = 1'b0;
    for (int i = 0; i < 4; i++) tick("liud_up");
    check("liud_up.wrap_tas", int'(bus.tas_out), 8'h10);
    check("liud_up.wrap_done", int'(bus.done_out), 1);

    // LIUD down from reverse start with a 3-cycle hold mid-run
    drive(0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick("liud_dn_load");
    bus.r_in = 1'b0;
    tick("liud_dn");
    bus.hold_in = 1'b1;
    for (int i = 0; i < 3; i++) tick("liud_hold");
    check("liud_hold.frozen", int'(bus.tas_out), 8'h12);
    bus.hold_in = 1'b0;
    for (int i = 0; i < 3; i++) tick("liud_dn");
    check("liud_dn.wrap_tas", int'(bus.tas_out), 8'h13);
    check("liud_dn.wrap_done", int'(bus.done_out), 1);

    // Simultaneous s_in and r_in: start address wins
    drive(0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick("s_and_r");
    check("s_and_r.const", int'(bus.tas_out), 8'h10);

    // PRUD full period up, then down, from the seed
    for (int dir = 1; dir >= 0; dir--) begin
      drive(1, dir[0], 1'b1, 1'b0, 1'b0);
      tick("prud_load");
      bus.s_in = 1'b0;
      foreach (seen[k]) seen[k] = 1'b0;
      distinct = 0;
      dones    = 0;
      for (int i = 0; i < 255; i++) begin
        tick(dir ? "prud_up" : "prud_dn");
        if (!seen[bus.tas_out]) distinct++;
        seen[bus.tas_out] = 1'b1;
        if (bus.done_out) dones++;
      end
      check("prud.distinct", distinct, 255);
      check("prud.no_zero", int'(seen[0]), 0);
      check("prud.done_count", dones, 1);
      check("prud.end_seed", int'(bus.tas_out), SEED);
    end

    // ROWF full range up
    bus.lo_in = 8'h00;
    bus.hi_in = 8'hFF;
    drive(2, 1'b1, 1'b1, 1'b0, 1'b0);
    tick("rowf_load");
    bus.s_in = 1'b0;
    tick("rowf");
    check("rowf.second", int'(bus.tas_out), 8'h10);
    for (int i = 0; i < 15; i++) tick("rowf");
    check("rowf.col_advance", int'(bus.tas_out), 8'h01);
    for (int i = 0; i < 240; i++) tick("rowf");
    check("rowf.wrap_tas", int'(bus.tas_out), 8'h00);
    check("rowf.wrap_done", int'(bus.done_out), 1);

    // Randomized traffic, with an occasional asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        bus.lo_in = 8'($urandom);
        bus.hi_in = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                                : 8'(bus.lo_in + $urandom_range(0, 15));
      end
      drive($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2),
            1'($urandom_range(0, 7) != 0 ? bus.updwn_in : 1'($urandom)),
            $urandom_range(0, 40) == 0, $urandom_range(0, 40) == 0,
            $urandom_range(0, 7) == 0);
      if (i % 997 == 500) begin
        rst = 1'b0;
        #1;
        check("async_rst.tas", int'(bus.tas_out), 0);
        check("async_rst.done", int'(bus.done_out), 0);
        m_idx = 0; m_tas = 0; m_done = 0;
        @(negedge clk);
        rst = 1'b1;
      end
      tick("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
